// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  localparam int DEF_NUM_REQ      = 3;
  localparam int DEF_TIMEOUT_CLKS = 4096;
  localparam int IDX_W            = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [7:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first requester at or above last_grant+1, wrapping to 0.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [IDX_W-1:0] start;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (last_grant >= IDX_W'(NUM_REQ - 1)) start = '0;
    else                                   start = last_grant + IDX_W'(1);
    // Upper segment first, then wrap around to the low indices.
    for (int n = 0; n < NUM_REQ; n++) begin
      if (!found && req[n] && (n >= int'(start))) begin
        grant[n] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int n = 0; n < NUM_REQ; n++) begin
      if (!found && req[n]) begin
        grant[n] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter feeding one UART byte transmitter.
//   state | meaning
//   IDLE  | no owner; pick next requester round-robin
//   FETCH | owner granted, o_ready high, waiting for a byte (timeout runs)
//   START | byte latched, waiting for transmitter to go idle before strobing
//   WAIT  | byte in flight, waiting for i_tx_done
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_byte,
  input  logic [NUM_REQ-1:0]   i_valid,
  input  logic [NUM_REQ-1:0]   i_last,
  output logic [NUM_REQ-1:0]   o_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic                 o_timeout
);

  localparam int               CNT_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   last_grant;
  logic               last_flag;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_valid;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_byte;
  logic [IDX_W-1:0]   cur_idx;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (i_req),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // The one-hot grant doubles as the mux select for the owner's lane.
  always_comb begin
    sel_byte = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (o_grant[n]) sel_byte = i_byte[8*n +: 8];
    end
    sel_valid = |(i_valid & o_grant);
    sel_last  = |(i_last & o_grant);
    cur_idx   = oh2idx(8'(o_grant));
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      o_grant    <= '0;
      o_ready    <= '0;
      o_busy     <= 1'b0;
      o_tx_dv    <= 1'b0;
      o_tx_byte  <= '0;
      o_timeout  <= 1'b0;
      cnt        <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      last_flag  <= 1'b0;
    end else begin
      o_tx_dv   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            o_grant <= pick_grant;
            o_ready <= pick_grant;
            o_busy  <= 1'b1;
            cnt     <= '0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          // A byte arriving on the last allowed cycle still wins over timeout.
          if (sel_valid) begin
            o_tx_byte <= sel_byte;
            last_flag <= sel_last;
            o_ready   <= '0;
            state     <= START;
          end else if (cnt == CNT_LAST) begin
            o_timeout  <= 1'b1;
            o_grant    <= '0;
            o_ready    <= '0;
            o_busy     <= 1'b0;
            last_grant <= cur_idx;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        START: begin
          if (!i_tx_active) begin
            o_tx_dv <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (i_tx_done) begin
            if (last_flag) begin
              o_grant    <= '0;
              o_busy     <= 1'b0;
              last_grant <= cur_idx;
              state      <= IDLE;
            end else begin
              o_ready <= o_grant;
              cnt     <= '0;
              state   <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vector table plus multi-cycle corner sequences.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req, valid, last;
  logic [23:0] bytes;
  logic        act, done;
  logic [2:0]  o_ready, o_grant;
  logic        o_busy, o_tx_dv, o_timeout;
  logic [7:0]  o_tx_byte;
  logic [16:0] snap;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.NUM_REQ(3), .TIMEOUT_CLKS(16)) dut (
    .clk         (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_byte      (bytes),
    .i_valid     (valid),
    .i_last      (last),
    .o_ready     (o_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_tx_dv     (o_tx_dv),
    .o_tx_byte   (o_tx_byte),
    .i_tx_active (act),
    .i_tx_done   (done),
    .o_timeout   (o_timeout)
  );

  assign snap = {o_grant, o_ready, o_busy, o_tx_dv, o_tx_byte, o_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req, valid, last;
    logic [23:0] bytes;
    logic        act, done;
    logic [16:0] want;
  } vec_t;

  vec_t tv[21];

  function automatic logic [16:0] ex(input logic [2:0] g, input logic [2:0] r, input logic b,
                                     input logic dv, input logic [7:0] by, input logic to);
    return {g, r, b, dv, by, to};
  endfunction

  function automatic vec_t mk(input logic [2:0] rq, input logic [2:0] vl, input logic [2:0] ls,
                              input logic [23:0] by, input logic ac, input logic dn,
                              input logic [16:0] w);
    vec_t v;
    v.req = rq; v.valid = vl; v.last = ls; v.bytes = by; v.act = ac; v.done = dn; v.want = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses;
    logic seen;

    // Single requester 0: 0D,0A,6D, then idle-time done, then contention rows.
    tv[0]  = mk(3'b001, 3'b000, 3'b000, 24'h000000, 0, 0, ex(3'b001, 3'b001, 1, 0, 8'h00, 0));
    tv[1]  = mk(3'b001, 3'b001, 3'b000, 24'h00000D, 0, 0, ex(3'b001, 3'b000, 1, 0, 8'h0D, 0));
    tv[2]  = mk(3'b001, 3'b000, 3'b000, 24'h000000, 0, 0, ex(3'b001, 3'b000, 1, 1, 8'h0D, 0));
    tv[3]  = mk(3'b001, 3'b000, 3'b000, 24'h000000, 1, 0, ex(3'b001, 3'b000, 1, 0, 8'h0D, 0));
    tv[4]  = mk(3'b001, 3'b000, 3'b000, 24'h000000, 1, 1, ex(3'b001, 3'b001, 1, 0, 8'h0D, 0));
    tv[5]  = mk(3'b001, 3'b001, 3'b000, 24'h00000A, 0, 0, ex(3'b001, 3'b000, 1, 0, 8'h0A, 0));
    tv[6]  = mk(3'b001, 3'b000, 3'b000, 24'h000000, 0, 0, ex(3'b001, 3'b000, 1, 1, 8'h0A, 0));
    tv[7]  = mk(3'b001, 3'b000, 3'b000, 24'h000000, 0, 1, ex(3'b001, 3'b001, 1, 0, 8'h0A, 0));
    tv[8]  = mk(3'b001, 3'b001, 3'b001, 24'h00006D, 0, 0, ex(3'b001, 3'b000, 1, 0, 8'h6D, 0));
    tv[9]  = mk(3'b001, 3'b000, 3'b000, 24'h000000, 0, 0, ex(3'b001, 3'b000, 1, 1, 8'h6D, 0));
    tv[10] = mk(3'b000, 3'b000, 3'b000, 24'h000000, 0, 1, ex(3'b000, 3'b000, 0, 0, 8'h6D, 0));
    tv[11] = mk(3'b000, 3'b000, 3'b000, 24'h000000, 0, 1, ex(3'b000, 3'b000, 0, 0, 8'h6D, 0));
    tv[12] = mk(3'b101, 3'b000, 3'b000, 24'h000000, 0, 0, ex(3'b100, 3'b100, 1, 0, 8'h6D, 0));
    tv[13] = mk(3'b101, 3'b101, 3'b101, 24'h220011, 0, 0, ex(3'b100, 3'b000, 1, 0, 8'h22, 0));
    tv[14] = mk(3'b101, 3'b000, 3'b000, 24'h000000, 0, 0, ex(3'b100, 3'b000, 1, 1, 8'h22, 0));
    tv[15] = mk(3'b101, 3'b000, 3'b000, 24'h000000, 0, 1, ex(3'b000, 3'b000, 0, 0, 8'h22, 0));
    tv[16] = mk(3'b101, 3'b000, 3'b000, 24'h000000, 0, 0, ex(3'b001, 3'b001, 1, 0, 8'h22, 0));
    tv[17] = mk(3'b010, 3'b001, 3'b001, 24'h000011, 0, 0, ex(3'b001, 3'b000, 1, 0, 8'h11, 0));
    tv[18] = mk(3'b010, 3'b000, 3'b000, 24'h000000, 1, 1, ex(3'b001, 3'b000, 1, 0, 8'h11, 0));
    tv[19] = mk(3'b010, 3'b000, 3'b000, 24'h000000, 0, 0, ex(3'b001, 3'b000, 1, 1, 8'h11, 0));
    tv[20] = mk(3'b000, 3'b000, 3'b000, 24'h000000, 0, 1, ex(3'b000, 3'b000, 0, 0, 8'h11, 0));

    rst = 1'b1; req = '0; valid = '0; last = '0; bytes = '0; act = 1'b0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'(snap), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      req = tv[i].req; valid = tv[i].valid; last = tv[i].last;
      bytes = tv[i].bytes; act = tv[i].act; done = tv[i].done;
      step();
      chk($sformatf("vec%0d", i + 1), 32'(snap), 32'(tv[i].want));
    end

    // Timeout on requester 1, then next requester in rotation.
    req = 3'b010; valid = '0; last = '0; bytes = '0; act = 1'b0; done = 1'b0;
    step();
    chk("to_grant", 32'(snap), 32'(ex(3'b010, 3'b010, 1, 0, 8'h11, 0)));
    req = 3'b111;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (o_timeout) seen = 1'b1;
    end
    chk("to_latency", 32'(n), 32'd16);
    chk("to_release", 32'(snap), 32'(ex(3'b000, 3'b000, 0, 0, 8'h11, 1)));
    step();
    chk("to_next", 32'(snap), 32'(ex(3'b100, 3'b100, 1, 0, 8'h11, 0)));

    // Byte offered on the final allowed FETCH cycle: handshake wins.
    repeat (15) step();
    chk("tie_hold", 32'(snap), 32'(ex(3'b100, 3'b100, 1, 0, 8'h11, 0)));
    valid = 3'b100; last = 3'b100; bytes = 24'h5A0000;
    step();
    chk("tie_handshake", 32'(snap), 32'(ex(3'b100, 3'b000, 1, 0, 8'h5A, 0)));
    valid = '0; last = '0; req = '0;
    step();
    chk("tie_dv", 32'(snap), 32'(ex(3'b100, 3'b000, 1, 1, 8'h5A, 0)));
    done = 1'b1;
    step();
    done = 1'b0;
    chk("tie_idle", 32'(snap), 32'(ex(3'b000, 3'b000, 0, 0, 8'h5A, 0)));

    // Transmitter busy for 5 cycles at START entry.
    act = 1'b1; req = 3'b001;
    step();
    chk("act_grant", 32'(snap), 32'(ex(3'b001, 3'b001, 1, 0, 8'h5A, 0)));
    valid = 3'b001; last = 3'b001; bytes = 24'h000077;
    step();
    chk("act_start", 32'(snap), 32'(ex(3'b001, 3'b000, 1, 0, 8'h77, 0)));
    valid = '0; last = '0; req = '0;
    pulses = 0;
    repeat (5) begin
      step();
      if (o_tx_dv) pulses++;
    end
    chk("act_hold", 32'(pulses), 32'd0);
    act = 1'b0;
    step();
    chk("act_go", 32'(snap), 32'(ex(3'b001, 3'b000, 1, 1, 8'h77, 0)));
    act = 1'b1;
    step();
    chk("act_once", 32'(snap), 32'(ex(3'b001, 3'b000, 1, 0, 8'h77, 0)));
    act = 1'b0; done = 1'b1;
    step();
    done = 1'b0;
    chk("act_idle", 32'(snap), 32'(ex(3'b000, 3'b000, 0, 0, 8'h77, 0)));

    // Reset during WAIT of byte 2 of a 4-byte frame from requester 1.
    req = 3'b010;
    step();
    chk("rst_grant", 32'(snap), 32'(ex(3'b010, 3'b010, 1, 0, 8'h77, 0)));
    valid = 3'b010; bytes = 24'h00A100;
    step();
    valid = '0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("rst_refetch", 32'(snap), 32'(ex(3'b010, 3'b010, 1, 0, 8'hA1, 0)));
    valid = 3'b010; bytes = 24'h00A200;
    step();
    valid = '0;
    step();
    chk("rst_byte2", 32'(snap), 32'(ex(3'b010, 3'b000, 1, 1, 8'hA2, 0)));
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 32'(snap), 32'h0);
    done = 1'b1; valid = 3'b010; req = 3'b010;
    pulses = 0;
    repeat (3) begin
      step();
      if (o_tx_dv) pulses++;
    end
    chk("rst_no_dv", 32'(pulses), 32'd0);
    chk("rst_hold", 32'(snap), 32'h0);
    rst = 1'b0; done = 1'b0; valid = '0; req = 3'b101;
    step();
    chk("rst_first", 32'(snap), 32'(ex(3'b001, 3'b001, 1, 0, 8'h00, 0)));
    valid = 3'b101; last = 3'b101; bytes = 24'h330044;
    step();
    chk("rst_byte_r0", 32'(snap), 32'(ex(3'b001, 3'b000, 1, 0, 8'h44, 0)));
    valid = '0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("rst_r0_done", 32'(snap), 32'(ex(3'b000, 3'b000, 0, 0, 8'h44, 0)));
    step();
    chk("rst_second", 32'(snap), 32'(ex(3'b100, 3'b100, 1, 0, 8'h44, 0)));
    valid = 3'b100;
    step();
    chk("rst_byte_r2", 32'(snap), 32'(ex(3'b100, 3'b000, 1, 0, 8'h33, 0)));
    valid = '0; last = '0; req = '0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("rst_r2_done", 32'(snap), 32'(ex(3'b000, 3'b000, 0, 0, 8'h33, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing the UART transmitter (legal range 1..8).
REQ-002 Parameter TIMEOUT_CLKS, default 4096: maximum cycles a granted requester may hold the grant in FETCH without presenting a byte.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  NUM_REQ  per-requester frame request, level.
REQ-006 i_byte  input  8*NUM_REQ  per-requester data byte, requester n on bits [8n+7:8n].
REQ-007 i_valid  input  NUM_REQ  per-requester byte valid.
REQ-008 i_last  input  NUM_REQ  per-requester last-byte-of-frame flag, qualified by i_valid.
REQ-009 o_ready  output  NUM_REQ  byte accept; at most one bit high.
REQ-010 o_grant  output  NUM_REQ  one-hot owner of the transmitter, all-zero when idle.
REQ-011 o_busy  output  1  high whenever any grant is held.
REQ-012 o_tx_dv  output  1  one-cycle start strobe to the UART_TX byte transmitter.
REQ-013 o_tx_byte  output  8  byte presented with o_tx_dv, held stable until the next load.
REQ-014 i_tx_active  input  1  transmitter busy indication.
REQ-015 i_tx_done  input  1  transmitter one-cycle byte-complete pulse.
REQ-016 o_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, FETCH, START and WAIT.
REQ-018 IDLE: if any i_req bit is high, the FSM SHALL select a winner round-robin, searching upward from (last_grant+1) mod NUM_REQ, set o_grant to the winner and enter FETCH on the next edge; otherwise it SHALL remain in IDLE.
REQ-019 FETCH: o_ready[g] SHALL be high, where g is the granted index; when i_valid[g] is also high, the block SHALL capture i_byte[g] into o_tx_byte and i_last[g] into a last flag, then enter START.
REQ-020 START: if i_tx_active is low, the block SHALL assert o_tx_dv for exactly one cycle and enter WAIT; if it is high, the block SHALL hold in START with o_tx_dv low.
REQ-021 WAIT: on i_tx_done, the block SHALL re-enter FETCH if the last flag is clear; if it is set, it SHALL clear o_grant, store g as last_grant and enter IDLE.
REQ-022 Grant is frame-atomic: bytes of different requesters SHALL never interleave, and i_req changes during a frame SHALL be ignored.
REQ-023 Latency: o_tx_dv SHALL rise in the cycle after the FETCH handshake edge, given i_tx_active is low; o_ready SHALL be high no earlier than one cycle after i_req is sampled in IDLE.
REQ-024 Timeout: a counter SHALL clear on FETCH entry and increment each FETCH cycle without handshake; on reaching TIMEOUT_CLKS-1, the block SHALL pulse o_timeout, release the grant, update last_grant and enter IDLE.
REQ-025 The timeout counter SHALL be clog2(TIMEOUT_CLKS) bits wide and SHALL never wrap.
REQ-026 A single-requester configuration (NUM_REQ=1) SHALL grant requester 0 whenever i_req is high.
REQ-027 i_tx_done outside WAIT SHALL be ignored.
REQ-028 A handshake and a timeout in the same cycle SHALL resolve to the handshake, with no o_timeout pulse.

Reset
REQ-029 While i_rst is high, the block SHALL drive: state IDLE, o_grant 0, o_ready 0, o_busy 0, o_tx_dv 0, o_tx_byte 8'h00, o_timeout 0, timeout counter 0, and last_grant NUM_REQ-1, so that requester 0 wins first.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no further o_tx_dv; reset SHALL take priority over every simultaneous event.

Structure
REQ-031 State encodings and the default NUM_REQ/TIMEOUT_CLKS SHALL reside in the shared package uart_pkg.
REQ-032 The rotating-priority winner selection SHALL be a combinational sub-module named uart_rr_pick, with inputs req and last_grant and outputs a one-hot grant and a valid flag.

Verification
REQ-033 Single requester 0 sends the 3-byte frame 0x0D,0x0A,0x6D (last on 0x6D) -> three o_tx_dv pulses, each after the previous i_tx_done, carrying those bytes in order; o_grant=001 throughout, then 000.
REQ-034 Requesters 0 and 2 request simultaneously after reset -> requester 0's whole frame is sent first, then requester 2's; on a repeated contention, requester 2 precedes 0 only if 0's frame was last served.
REQ-035 Requester 1 is granted and holds i_valid low with TIMEOUT_CLKS=16 -> o_timeout pulses 16 cycles after FETCH entry, grant clears and the next requester is served.
REQ-036 i_tx_active is held high at START entry for 5 cycles -> o_tx_dv stays low, then pulses once in the first cycle i_tx_active is low.
REQ-037 i_rst is pulsed during WAIT of byte 2 of 4 -> outputs return to reset values asynchronously, no further o_tx_dv, and the next request is granted to requester 0.
